csr_unit: RTL and testbench

- Machine-mode CSR file and trap/return controller for the RV32 core, directly downstream of the decode control unit.
- Consumes that unit's is_csr_instr, is_mret_instr, csr_write and csr_data_sel for the instruction in the execute slot.
- Performs Zicsr read-modify-write and MRET.
- Takes external, software and timer interrupts at instruction boundaries, then issues a registered redirect to the fetch stage.

---
 rtl/csr_pkg.sv | 50 +++++
 rtl/csr_unit_counter64.sv | 29 ++
 rtl/csr_unit.sv | 199 +++++++++++++++++++
 tb/tb_csr_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file: addresses, interrupt codes,
// register bit positions and the Zicsr read-modify-write helper.
package csr_pkg;

  localparam logic [11:0] CsrMstatus   = 12'h300;
  localparam logic [11:0] CsrMisa      = 12'h301;
  localparam logic [11:0] CsrMie       = 12'h304;
  localparam logic [11:0] CsrMtvec     = 12'h305;
  localparam logic [11:0] CsrMscratch  = 12'h340;
  localparam logic [11:0] CsrMepc      = 12'h341;
  localparam logic [11:0] CsrMcause    = 12'h342;
  localparam logic [11:0] CsrMip       = 12'h344;
  localparam logic [11:0] CsrMcycle    = 12'hB00;
  localparam logic [11:0] CsrMinstret  = 12'hB02;
  localparam logic [11:0] CsrMcycleh   = 12'hB80;
  localparam logic [11:0] CsrMinstreth = 12'hB82;
  localparam logic [11:0] CsrMhartid   = 12'hF14;

  localparam logic [3:0] IrqCodeMsi = 4'd3;
  localparam logic [3:0] IrqCodeMti = 4'd7;
  localparam logic [3:0] IrqCodeMei = 4'd11;

  localparam int unsigned MstatusMieBit  = 3;
  localparam int unsigned MstatusMpieBit = 7;
  localparam int unsigned IrqMsiBit      = 3;
  localparam int unsigned IrqMtiBit      = 7;
  localparam int unsigned IrqMeiBit      = 11;
  localparam logic [31:0] MieMask        = 32'h0000_0888;
  localparam logic [31:0] MstatusFixed   = 32'h0000_1800;

  localparam logic [11:0] Funct12Mret = 12'h302;

  typedef enum logic [1:0] {
    CsrOpNone = 2'b00,
    CsrOpRw   = 2'b01,
    CsrOpRs   = 2'b10,
    CsrOpRc   = 2'b11
  } csr_op_e;

  function automatic logic [31:0] csr_apply(csr_op_e op, logic [31:0] old_val,
                                            logic [31:0] operand);
    unique case (op)
      CsrOpRw: csr_apply = operand;
      CsrOpRs: csr_apply = old_val | operand;
      CsrOpRc: csr_apply = old_val & ~operand;
      default: csr_apply = old_val;
    endcase
  endfunction

endpackage

// File: rtl/csr_unit_counter64.sv
// 64-bit performance counter with per-half software write ports.
// Any write suppresses that cycle's increment for the whole counter.
module csr_counter64 (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] value_o
);

  logic [63:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i) cnt_d[31:0] = wdata_i;
    if (wr_hi_i) cnt_d[63:32] = wdata_i;
    if (!wr_lo_i && !wr_hi_i && inc_i) cnt_d = cnt_q + 64'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign value_o = cnt_q;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file with Zicsr read-modify-write, MRET and interrupt entry.
// Redirects to fetch are registered single-cycle pulses.
module csr_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  input  logic [31:0] pc_i,
  input  logic        is_csr_instr_i,
  input  logic        is_mret_instr_i,
  input  logic        csr_write_i,
  input  logic        csr_data_sel_i,
  input  logic [2:0]  func3_i,
  input  logic [11:0] csr_addr_i,
  input  logic [4:0]  rs1_addr_i,
  input  logic [31:0] rs1_data_i,
  input  logic        retire_i,
  input  logic        ext_irq_i,
  input  logic        sw_irq_i,
  input  logic        timer_irq_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        trap_taken_o,
  output logic        mret_o
);

  logic        mstatus_mie_d, mstatus_mie_q, mstatus_mpie_d, mstatus_mpie_q;
  logic [31:0] mie_d, mie_q, mip_d, mip_q, mtvec_d, mtvec_q;
  logic [31:0] mscratch_d, mscratch_q, mepc_d, mepc_q, mcause_d, mcause_q;
  logic        redirect_d, redirect_q, trap_d, trap_q, mret_d, mret_q;
  logic [31:0] redirect_pc_d, redirect_pc_q;
  logic [63:0] mcycle, minstret;

  logic [31:0] mstatus_rd, old_val, operand, new_val;
  logic        known, irq_pend, irq_take, mret_take, wr_occurs, wr_en, op_zero;
  logic [3:0]  irq_code;
  logic [31:0] irq_act;
  csr_op_e     op;
  logic        unused_bits;

  assign unused_bits = ^{func3_i[2], pc_i[1:0]};

  always_comb begin
    mstatus_rd                 = MstatusFixed;
    mstatus_rd[MstatusMieBit]  = mstatus_mie_q;
    mstatus_rd[MstatusMpieBit] = mstatus_mpie_q;
  end

  always_comb begin
    known   = 1'b1;
    old_val = '0;
    case (csr_addr_i)
      CsrMstatus:   old_val = mstatus_rd;
      CsrMisa:      old_val = MISA_VALUE;
      CsrMie:       old_val = mie_q;
      CsrMtvec:     old_val = mtvec_q;
      CsrMscratch:  old_val = mscratch_q;
      CsrMepc:      old_val = mepc_q;
      CsrMcause:    old_val = mcause_q;
      CsrMip:       old_val = mip_q;
      CsrMcycle:    old_val = mcycle[31:0];
      CsrMinstret:  old_val = minstret[31:0];
      CsrMcycleh:   old_val = mcycle[63:32];
      CsrMinstreth: old_val = minstret[63:32];
      CsrMhartid:   old_val = HART_ID;
      default:      known   = 1'b0;
    endcase
  end

  assign csr_rdata_o = is_csr_instr_i ? old_val : 32'h0;

  assign op      = csr_op_e'(func3_i[1:0]);
  assign operand = csr_data_sel_i ? {27'b0, rs1_addr_i} : rs1_data_i;
  assign new_val = csr_apply(op, old_val, operand);
  assign op_zero = ((op == CsrOpRs) || (op == CsrOpRc)) && (rs1_addr_i == 5'd0);

  // External beats software beats timer.
  assign irq_act  = mie_q & mip_q;
  assign irq_pend = mstatus_mie_q & (|irq_act);
  assign irq_code = irq_act[IrqMeiBit] ? IrqCodeMei :
                    irq_act[IrqMsiBit] ? IrqCodeMsi : IrqCodeMti;

  assign irq_take  = en_i & irq_pend & ~redirect_q;
  assign mret_take = en_i & is_mret_instr_i & ~irq_take & ~redirect_q;
  assign wr_occurs = en_i & is_csr_instr_i & csr_write_i & ~irq_take & ~mret_take &
                     ~redirect_q & (op != CsrOpNone) & ~op_zero;
  assign csr_illegal_o = en_i & is_csr_instr_i &
                         (~known | (wr_occurs & (csr_addr_i[11:10] == 2'b11)));
  assign wr_en = wr_occurs & ~csr_illegal_o;

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mip_d          = '0;
    mip_d[IrqMsiBit] = sw_irq_i;
    mip_d[IrqMtiBit] = timer_irq_i;
    mip_d[IrqMeiBit] = ext_irq_i;
    redirect_d     = 1'b0;
    trap_d         = 1'b0;
    mret_d         = 1'b0;
    redirect_pc_d  = redirect_pc_q;
    if (irq_take) begin
      mepc_d         = {pc_i[31:2], 2'b00};
      mcause_d       = {1'b1, 27'b0, irq_code};
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
      redirect_d     = 1'b1;
      trap_d         = 1'b1;
      redirect_pc_d  = mtvec_q;
    end else if (mret_take) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
      redirect_d     = 1'b1;
      mret_d         = 1'b1;
      redirect_pc_d  = mepc_q;
    end else if (wr_en) begin
      case (csr_addr_i)
        CsrMstatus: begin
          mstatus_mie_d  = new_val[MstatusMieBit];
          mstatus_mpie_d = new_val[MstatusMpieBit];
        end
        CsrMie:      mie_d      = new_val & MieMask;
        CsrMtvec:    mtvec_d    = {new_val[31:2], 2'b00};
        CsrMscratch: mscratch_d = new_val;
        CsrMepc:     mepc_d     = {new_val[31:2], 2'b00};
        CsrMcause:   mcause_d   = new_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mip_q          <= '0;
      mtvec_q        <= {MTVEC_RESET[31:2], 2'b00};
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      redirect_q     <= 1'b0;
      trap_q         <= 1'b0;
      mret_q         <= 1'b0;
      redirect_pc_q  <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mip_q          <= mip_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      redirect_q     <= redirect_d;
      trap_q         <= trap_d;
      mret_q         <= mret_d;
      redirect_pc_q  <= redirect_pc_d;
    end
  end

  csr_counter64 u_mcycle (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (1'b1),
    .wr_lo_i (wr_en && (csr_addr_i == CsrMcycle)),
    .wr_hi_i (wr_en && (csr_addr_i == CsrMcycleh)),
    .wdata_i (new_val),
    .value_o (mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (retire_i),
    .wr_lo_i (wr_en && (csr_addr_i == CsrMinstret)),
    .wr_hi_i (wr_en && (csr_addr_i == CsrMinstreth)),
    .wdata_i (new_val),
    .value_o (minstret)
  );

  assign redirect_o    = redirect_q;
  assign redirect_pc_o = redirect_pc_q;
  assign trap_taken_o  = trap_q;
  assign mret_o        = mret_q;

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: stimulus pushes expected reads/redirects into
// queues, a negedge monitor pops and compares whenever the DUT presents them.
module tb_csr_unit;
  import csr_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en_i = 1'b0, is_csr_instr_i = 1'b0, is_mret_instr_i = 1'b0;
  logic        csr_write_i = 1'b0, csr_data_sel_i = 1'b0;
  logic [31:0] pc_i = '0, rs1_data_i = '0;
  logic [2:0]  func3_i = '0;
  logic [11:0] csr_addr_i = '0;
  logic [4:0]  rs1_addr_i = '0;
  logic        retire_i = 1'b0, ext_irq_i = 1'b0, sw_irq_i = 1'b0, timer_irq_i = 1'b0;
  logic [31:0] csr_rdata_o, redirect_pc_o;
  logic        csr_illegal_o, redirect_o, trap_taken_o, mret_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        ill;
    bit          chk;
  } rd_exp_t;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        trap;
    logic        mret;
  } rdr_exp_t;

  rd_exp_t  rd_q[$];
  rdr_exp_t rdr_q[$];
  rd_exp_t  re;
  rdr_exp_t de;

  csr_unit dut (
    .clk            (clk),
    .reset          (reset),
    .en_i           (en_i),
    .pc_i           (pc_i),
    .is_csr_instr_i (is_csr_instr_i),
    .is_mret_instr_i(is_mret_instr_i),
    .csr_write_i    (csr_write_i),
    .csr_data_sel_i (csr_data_sel_i),
    .func3_i        (func3_i),
    .csr_addr_i     (csr_addr_i),
    .rs1_addr_i     (rs1_addr_i),
    .rs1_data_i     (rs1_data_i),
    .retire_i       (retire_i),
    .ext_irq_i      (ext_irq_i),
    .sw_irq_i       (sw_irq_i),
    .timer_irq_i    (timer_irq_i),
    .csr_rdata_o    (csr_rdata_o),
    .csr_illegal_o  (csr_illegal_o),
    .redirect_o     (redirect_o),
    .redirect_pc_o  (redirect_pc_o),
    .trap_taken_o   (trap_taken_o),
    .mret_o         (mret_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic en, input logic is_csr, input logic is_mret,
                      input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rs1a,
                      input logic [31:0] rs1d, input logic [31:0] pc);
    @(posedge clk);
    #1;
    en_i = en; is_csr_instr_i = is_csr; is_mret_instr_i = is_mret;
    csr_write_i = is_csr; csr_data_sel_i = f3[2]; func3_i = f3;
    csr_addr_i = addr; rs1_addr_i = rs1a; rs1_data_i = rs1d; pc_i = pc;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 3'b000, 12'h000, 5'd0, 32'h0, 32'h0);
  endtask

  task automatic csr(input string name, input logic [2:0] f3, input logic [11:0] addr,
                     input logic [4:0] rs1a, input logic [31:0] rs1d,
                     input logic [31:0] exp, input logic ill, input bit do_chk);
    step(1'b1, 1'b1, 1'b0, f3, addr, rs1a, rs1d, 32'h0);
    rd_q.push_back('{name, exp, ill, do_chk});
  endtask

  task automatic rd(input string name, input logic [11:0] addr, input logic [31:0] exp);
    csr(name, 3'b010, addr, 5'd0, 32'h0, exp, 1'b0, 1'b1);
  endtask

  // Monitor: reads are presented combinationally, redirects one cycle later.
  always @(negedge clk) begin
    if (!reset) begin
      if (en_i && is_csr_instr_i) begin
        if (rd_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_read: got rdata %h with empty queue", csr_rdata_o);
        end else begin
          re = rd_q.pop_front();
          if (re.chk) begin
            checks++;
            if (csr_rdata_o !== re.rdata || csr_illegal_o !== re.ill) begin
              failures++;
              $display("FAIL %s: got rdata %h ill %b expected rdata %h ill %b",
                       re.name, csr_rdata_o, csr_illegal_o, re.rdata, re.ill);
            end
          end
        end
      end
      if (redirect_o) begin
        checks++;
        if (rdr_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_redirect: got pc %h with empty queue", redirect_pc_o);
        end else begin
          de = rdr_q.pop_front();
          if (redirect_pc_o !== de.pc || trap_taken_o !== de.trap || mret_o !== de.mret) begin
            failures++;
            $display("FAIL %s: got pc %h trap %b mret %b expected pc %h trap %b mret %b",
                     de.name, redirect_pc_o, trap_taken_o, mret_o, de.pc, de.trap, de.mret);
          end
        end
      end
    end
  end

  initial begin
    #1;
    chk("reset_redirect", {31'b0, redirect_o}, 32'h0);
    chk("reset_trap", {31'b0, trap_taken_o}, 32'h0);
    chk("reset_mret", {31'b0, mret_o}, 32'h0);
    chk("reset_redirect_pc", redirect_pc_o, 32'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    rd("mstatus_reset", CsrMstatus, 32'h0000_1800);
    rd("misa", CsrMisa, 32'h4000_0100);
    rd("mhartid", CsrMhartid, 32'h0);
    rd("minstret_reset", CsrMinstret, 32'h0);

    csr("csrrw_mscratch", 3'b001, CsrMscratch, 5'd1, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1);
    csr("csrrs_x0_mscratch", 3'b010, CsrMscratch, 5'd0, 32'h1234, 32'hDEAD_BEEF, 1'b0, 1'b1);
    rd("mscratch_kept", CsrMscratch, 32'hDEAD_BEEF);

    csr("csrrsi_mstatus", 3'b110, CsrMstatus, 5'd8, 32'h0, 32'h0000_1800, 1'b0, 1'b1);
    csr("csrrci_mstatus", 3'b111, CsrMstatus, 5'd8, 32'h0, 32'h0000_1808, 1'b0, 1'b1);
    rd("mstatus_cleared", CsrMstatus, 32'h0000_1800);

    csr("csrrw_mtvec", 3'b001, CsrMtvec, 5'd2, 32'h0000_0103, 32'h0, 1'b0, 1'b1);
    rd("mtvec_aligned", CsrMtvec, 32'h0000_0100);
    csr("csrrw_mie_all", 3'b001, CsrMie, 5'd2, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1);
    csr("csrrw_mie_meie", 3'b001, CsrMie, 5'd2, 32'h0000_0800, 32'h0000_0888, 1'b0, 1'b1);
    csr("csrrw_misa", 3'b001, CsrMisa, 5'd2, 32'h0, 32'h4000_0100, 1'b0, 1'b1);
    rd("misa_kept", CsrMisa, 32'h4000_0100);

    ext_irq_i = 1'b1;
    idle();
    rd("mip_ext", CsrMip, 32'h0000_0800);
    csr("enable_mie", 3'b110, CsrMstatus, 5'd8, 32'h0, 32'h0000_1800, 1'b0, 1'b1);

    // Plain instruction at 0x2004 gets interrupted.
    step(1'b1, 1'b0, 1'b0, 3'b000, 12'h000, 5'd0, 32'h0, 32'h0000_2004);
    rdr_q.push_back('{"trap_ext", 32'h0000_0100, 1'b1, 1'b0});
    csr("shadow_after_trap", 3'b001, CsrMscratch, 5'd1, 32'h5555, 32'hDEAD_BEEF, 1'b0, 1'b1);
    ext_irq_i = 1'b0;
    rd("mepc_trap", CsrMepc, 32'h0000_2004);
    rd("mcause_trap", CsrMcause, 32'h8000_000B);
    rd("mstatus_trap", CsrMstatus, 32'h0000_1880);
    rd("mscratch_shadow", CsrMscratch, 32'hDEAD_BEEF);

    step(1'b1, 1'b0, 1'b1, 3'b000, Funct12Mret, 5'd0, 32'h0, 32'h0000_0100);
    rdr_q.push_back('{"mret", 32'h0000_2004, 1'b0, 1'b1});
    csr("shadow_after_mret", 3'b001, CsrMscratch, 5'd1, 32'h1111, 32'hDEAD_BEEF, 1'b0, 1'b1);
    rd("mstatus_mret", CsrMstatus, 32'h0000_1888);
    rd("mscratch_mret_shadow", CsrMscratch, 32'hDEAD_BEEF);

    // Interrupt collides with a CSRRW: trap wins, write is squashed.
    ext_irq_i = 1'b1;
    idle();
    step(1'b1, 1'b1, 1'b0, 3'b001, CsrMscratch, 5'd1, 32'h77, 32'h0000_3000);
    rd_q.push_back('{"csrrw_vs_irq", 32'hDEAD_BEEF, 1'b0, 1'b1});
    rdr_q.push_back('{"trap_vs_csr", 32'h0000_0100, 1'b1, 1'b0});
    idle();
    ext_irq_i = 1'b0;
    rd("mscratch_squashed", CsrMscratch, 32'hDEAD_BEEF);
    rd("mepc_trap2", CsrMepc, 32'h0000_3000);
    rd("mstatus_trap2", CsrMstatus, 32'h0000_1880);

    csr("write_mcycle", 3'b001, CsrMcycle, 5'd1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
    rd("mcycleh_before", CsrMcycleh, 32'h0);
    rd("mcycleh_carry", CsrMcycleh, 32'h1);
    rd("mcycle_wrapped", CsrMcycle, 32'h1);

    csr("write_mhartid", 3'b001, CsrMhartid, 5'd1, 32'h5, 32'h0, 1'b1, 1'b1);
    rd("mhartid_kept", CsrMhartid, 32'h0);
    rd("unknown_addr", 12'h7C0, 32'h0);
    rd_q[rd_q.size() - 1].ill = 1'b1;

    retire_i = 1'b1;
    repeat (3) idle();
    retire_i = 1'b0;
    rd("minstret_three", CsrMinstret, 32'h3);

    idle();
    #2 reset = 1'b1;
    #1;
    chk("midreset_redirect", {31'b0, redirect_o}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    rd("mscratch_after_reset", CsrMscratch, 32'h0);
    rd("mstatus_after_reset", CsrMstatus, 32'h0000_1800);
    rd("mtvec_after_reset", CsrMtvec, 32'h0);
    idle();
    idle();

    chk("read_queue_drained", rd_q.size(), 32'h0);
    chk("redirect_queue_drained", rdr_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
